// File: rtl/afu_delay_pkg.sv
// Shared constants and types for the AFU delay-sweep control stage.
package afu_delay_pkg;

  // Prefix that marks a word as a delay-queue update; the queue matches on it.
  localparam logic [56:0] QUEUE_UPDATE_MAGIC = {4'b1010, 49'd0, 4'b0101};

  localparam logic [2:0] CSR_CTRL   = 3'd0;
  localparam logic [2:0] CSR_START  = 3'd1;
  localparam logic [2:0] CSR_END    = 3'd2;
  localparam logic [2:0] CSR_STEP   = 3'd3;
  localparam logic [2:0] CSR_DWELL  = 3'd4;
  localparam logic [2:0] CSR_STATUS = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DWELL = 2'd2,
    S_DONE  = 2'd3
  } t_sweep_state;

  typedef struct packed {
    logic       err;
    logic       dir;
    logic [1:0] state;
    logic [6:0] cur_delay;
  } t_status;

endpackage

// File: rtl/afu_delay_sweep_if.sv
// CSR bus plus delay-queue update outputs of the delay-sweep stage.
interface afu_delay_sweep_if;
  logic        csr_wr_en;
  logic [2:0]  csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic [63:0] afu_data;
  logic        busy;
  logic        done;
  logic [6:0]  cur_delay;

  modport master (output csr_wr_en, csr_addr, csr_wdata,
                  input  csr_rdata, afu_data, busy, done, cur_delay);
  modport slave  (input  csr_wr_en, csr_addr, csr_wdata,
                  output csr_rdata, afu_data, busy, done, cur_delay);
endinterface

// File: rtl/afu_delay_csr.sv
// Register file for the delay sweep: config regs, CTRL strobes, sticky err, readback.
module afu_delay_csr
  import afu_delay_pkg::*;
#(
  parameter int DWELL_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  logic [2:0]         i_addr,
  input  logic [63:0]        i_wdata,
  input  logic               i_busy,
  input  logic               i_dir,
  input  logic [1:0]         i_state,
  input  logic [6:0]         i_cur_delay,
  output logic [63:0]        o_rdata,
  output logic [6:0]         o_start_val,
  output logic [6:0]         o_end_val,
  output logic [6:0]         o_step_val,
  output logic [DWELL_W-1:0] o_dwell,
  output logic               o_start,
  output logic               o_stop,
  output logic               o_mode
);

  logic [6:0]         r_start;
  logic [6:0]         r_end;
  logic [6:0]         r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_err;

  logic w_ctrl_wr, w_cfg_wr, w_start_req, w_bad_range, w_start_err, w_err_clr;
  t_status w_status;

  assign w_ctrl_wr   = i_wr_en && (i_addr == CSR_CTRL);
  assign w_cfg_wr    = i_wr_en && (i_addr >= CSR_START) && (i_addr <= CSR_DWELL);
  // stop in the same write as start wins, so that start is dropped silently
  assign o_stop      = w_ctrl_wr && i_wdata[1];
  assign w_start_req = w_ctrl_wr && i_wdata[0] && !i_wdata[1];
  assign w_bad_range = i_wdata[2] && (r_start > r_end);
  assign o_start     = w_start_req && !i_busy && !w_bad_range;
  assign w_start_err = w_start_req && (i_busy || w_bad_range);
  assign w_err_clr   = i_wr_en && (i_addr == CSR_STATUS) && i_wdata[0];
  assign o_mode      = i_wdata[2];

  assign o_start_val = r_start;
  assign o_end_val   = r_end;
  assign o_step_val  = (r_step == 7'd0) ? 7'd1 : r_step;
  assign o_dwell     = r_dwell;

  // config registers; writes while a sequence runs are dropped
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_start <= 7'd32;
      r_end   <= 7'd32;
      r_step  <= 7'd1;
      r_dwell <= '0;
    end else if (w_cfg_wr && !i_busy) begin
      case (i_addr)
        CSR_START: r_start <= i_wdata[6:0];
        CSR_END:   r_end   <= i_wdata[6:0];
        CSR_STEP:  r_step  <= i_wdata[6:0];
        default:   r_dwell <= i_wdata[DWELL_W-1:0];
      endcase
    end
  end

  // sticky error flag, cleared by writing 1 to STATUS bit 0
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                   r_err <= 1'b0;
    else if (w_start_err || (w_cfg_wr && i_busy)) r_err <= 1'b1;
    else if (w_err_clr)                          r_err <= 1'b0;
  end

  // side-effect-free readback mux
  always_comb begin
    w_status           = '0;
    w_status.err       = r_err;
    w_status.dir       = i_dir;
    w_status.state     = i_state;
    w_status.cur_delay = i_cur_delay;
    o_rdata            = 64'd0;
    case (i_addr)
      CSR_START:  o_rdata = {57'd0, r_start};
      CSR_END:    o_rdata = {57'd0, r_end};
      CSR_STEP:   o_rdata = {57'd0, r_step};
      CSR_DWELL:  o_rdata = 64'(r_dwell);
      CSR_STATUS: o_rdata = {53'd0, w_status};
      default:    o_rdata = 64'd0;
    endcase
  end

endmodule

// File: rtl/afu_delay_sweep.sv
// Delay-sweep FSM driving the AFU delay-queue update word.
// Optional feature: define AFU_DELAY_SWEEP_TRIANGLE_EN for up/down triangle sweeps.
module afu_delay_sweep
  import afu_delay_pkg::*;
#(
  parameter logic [56:0] MAGIC   = QUEUE_UPDATE_MAGIC,
  parameter int          DWELL_W = 32
) (
  input  logic afu_clk,
  input  logic afu_rst,
  afu_delay_sweep_if.slave bus
);

  t_sweep_state       r_state, w_state_nxt;
  logic [6:0]         r_next;
  logic               r_mode;
  logic [DWELL_W-1:0] r_cnt;
  logic [63:0]        r_afu_data;
  logic [6:0]         r_cur_delay;
  logic               r_done;
  logic               w_dir;

  logic [6:0]         w_start_val, w_end_val, w_step;
  logic [DWELL_W-1:0] w_dwell;
  logic               w_start, w_stop, w_mode;
  logic               w_busy, w_issue, w_done_set, w_cnt_zero;
  logic [7:0]         w_inc, w_dec;
  logic [6:0]         w_up, w_dn;

  afu_delay_csr #(.DWELL_W(DWELL_W)) u_csr (
    .i_clk(afu_clk), .i_rst(afu_rst),
    .i_wr_en(bus.csr_wr_en), .i_addr(bus.csr_addr), .i_wdata(bus.csr_wdata),
    .i_busy(w_busy), .i_dir(w_dir), .i_state(r_state), .i_cur_delay(r_cur_delay),
    .o_rdata(bus.csr_rdata),
    .o_start_val(w_start_val), .o_end_val(w_end_val), .o_step_val(w_step),
    .o_dwell(w_dwell), .o_start(w_start), .o_stop(w_stop), .o_mode(w_mode)
  );

  // 8-bit step arithmetic so sums past 127 clamp instead of wrapping
  assign w_inc      = {1'b0, r_next} + {1'b0, w_step};
  assign w_up       = (w_inc > {1'b0, w_end_val}) ? w_end_val : w_inc[6:0];
  assign w_dec      = {1'b0, r_next} - {1'b0, w_step};
  assign w_dn       = (w_dec[7] || (w_dec[6:0] < w_start_val)) ? w_start_val : w_dec[6:0];
  assign w_cnt_zero = (r_cnt == '0);

`ifdef AFU_DELAY_SWEEP_TRIANGLE_EN
  logic r_dir;
  assign w_dir = r_dir;
`else
  assign w_dir = 1'b0;
`endif

  // state register
  always_ff @(posedge afu_clk or posedge afu_rst) begin
    if (afu_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state logic; stop overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) w_state_nxt = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  if (w_start) w_state_nxt = S_ISSUE;
        S_ISSUE: w_state_nxt = r_mode ? S_DWELL : S_DONE;
        S_DWELL:
          if (w_cnt_zero) begin
`ifdef AFU_DELAY_SWEEP_TRIANGLE_EN
            w_state_nxt = S_ISSUE;
`else
            w_state_nxt = (r_next == w_end_val) ? S_DONE : S_ISSUE;
`endif
          end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_issue    = (r_state == S_ISSUE) && !w_stop;
    w_done_set = (r_state == S_DONE) && !w_stop;
  end

  // sweep datapath: next delay, direction, dwell counter, latched mode
  always_ff @(posedge afu_clk or posedge afu_rst) begin
    if (afu_rst) begin
      r_next <= 7'd0;
      r_mode <= 1'b0;
      r_cnt  <= '0;
`ifdef AFU_DELAY_SWEEP_TRIANGLE_EN
      r_dir  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE:
          if (w_start) begin
            r_next <= w_start_val;
            r_mode <= w_mode;
`ifdef AFU_DELAY_SWEEP_TRIANGLE_EN
            r_dir  <= 1'b0;
`endif
          end
        S_ISSUE: r_cnt <= w_dwell;
        S_DWELL:
          if (!w_cnt_zero) r_cnt <= r_cnt - DWELL_W'(1);
          else begin
`ifdef AFU_DELAY_SWEEP_TRIANGLE_EN
            if (!r_dir) begin
              if (r_next == w_end_val) begin r_dir <= 1'b1; r_next <= w_dn; end
              else                            r_next <= w_up;
            end else begin
              if (r_next == w_start_val) begin r_dir <= 1'b0; r_next <= w_up; end
              else                              r_next <= w_dn;
            end
`else
            r_next <= w_up;
`endif
          end
        default: ;
      endcase
    end
  end

  // registered outputs: one update word per ISSUE, done one cycle after DONE
  always_ff @(posedge afu_clk or posedge afu_rst) begin
    if (afu_rst) begin
      r_afu_data  <= 64'd0;
      r_cur_delay <= 7'd0;
      r_done      <= 1'b0;
    end else begin
      r_afu_data <= w_issue ? {MAGIC, r_next} : 64'd0;
      if (w_issue) r_cur_delay <= r_next;
      r_done     <= w_done_set;
    end
  end

  assign bus.afu_data  = r_afu_data;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.cur_delay = r_cur_delay;

endmodule

// File: doc/afu_delay_sweep.md
# afu_delay_sweep

Control-plane stage that drives the 64-bit `afu_data` delay-control word consumed by the AFU read-response delay queue. A small CSR file takes writes from host/test logic. A sweep FSM then emits single-cycle update words `{QUEUE_UPDATE_MAGIC, delay[6:0]}`, either once (static) or stepping the minimum response delay across a programmed range with a programmable dwell. This automates latency sweeps without host intervention per step.

## Interface
- `MAGIC`, default `QUEUE_UPDATE_MAGIC` (57-bit, from package): prefix placed in `afu_data[63:7]` on update cycles.
- `DWELL_W`, default 32: width of the dwell counter/register.
- `afu_clk`  in  1  sole clock.
- `afu_rst`  in  1  reset, asynchronous and active-high.
- `csr_wr_en`  in  1  write strobe, one cycle per write.
- `csr_addr`  in  3  register index, 0..5.
- `csr_wdata`  in  64  write data.
- `csr_rdata`  out  64  combinational readback of `csr_addr`.
- `afu_data`  out  64  update word to the delay queue, registered; 64'h0 when no update.
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `cur_delay`  out  7  last value issued.

## Operation
- **Registers**
  - 0 CTRL (write-only strobes): bit0 start, bit1 stop, bit2 mode (0 static, 1 sweep; latched on start).
  - 1 START[6:0].
  - 2 END[6:0].
  - 3 STEP[6:0]; 0 is treated as 1.
  - 4 DWELL[DWELL_W-1:0].
  - 5 STATUS (read-only): {err, dir, state[1:0], cur_delay}.
- **Error cases:** each sets sticky `err`. Writing any STATUS bit 0 with 1 clears `err`.
  - Config writes (addr 1-4) while busy are ignored.
  - start while busy is ignored.
  - start in sweep mode with START > END is rejected; FSM stays IDLE.
- **FSM states:** IDLE, ISSUE, DWELL, DONE.
  - IDLE→ISSUE on accepted start; load `next` = START, dir = up.
  - ISSUE → next edge:
    - register `afu_data <= {MAGIC, next}` and `cur_delay <= next`.
    - static: →DONE.
    - sweep: load dwell counter = DWELL, →DWELL.
  - DWELL: decrement each cycle. When the count is 0:
    - ascending, `next` == END: →DONE.
    - otherwise: `next` = min(next+STEP, END) (8-bit sum, no wrap past 127), →ISSUE.
  - DONE: `done` = 1 for one cycle, →IDLE.
- **Stop:** from any state, stop → IDLE at next edge. No further update word is issued. `done` is not pulsed.
- **afu_data:** non-zero for exactly one cycle per ISSUE, 64'h0 otherwise.

## Timing
- **Reset values:** `afu_data` = 0, `busy` = 0, `done` = 0, `cur_delay` = 0, `csr_rdata` reflects reset registers.
  - START = 32, END = 32, STEP = 1, DWELL = 0, err = 0, state IDLE.
  - Async reset mid-sequence: all outputs return to reset values immediately. No partial word is emitted.
- **Latency:** start sampled at edge E0 → ISSUE in cycle after E0 → `afu_data` valid in cycle after E1.
- **Update period in sweep:** DWELL+2 cycles (ISSUE + DWELL+1 dwell cycles).
- **Simultaneous start and stop in the same CTRL write:** stop wins; FSM stays or returns to IDLE.
- `csr_rdata` has no read side effects.

## Configuration
- `AFU_DELAY_SWEEP_TRIANGLE_EN` defined:
  - On reaching END ascending, set dir = down and continue from DWELL with `next` = max(next−STEP, START), floor at START (no underflow).
  - On reaching START descending, reverse to up again.
  - Runs until stop; DONE is never entered in sweep mode.
- Undefined: single ascending pass then DONE; dir is constant 0.

## Structure
- Package `afu_delay_pkg` holds:
  - `QUEUE_UPDATE_MAGIC` (57'b1010…0101, shared with the delay queue).
  - CSR address localparams.
  - `t_sweep_state` enum.
  - STATUS packed struct.
- One natural sub-module, `afu_delay_csr`: register file, err logic, readback mux. The FSM and output register live in the top.

## Test plan
- Reset, static mode: write START=40, then CTRL=0x1 → exactly one cycle of `afu_data` = {MAGIC,7'd40} two edges after the write; `done` the next cycle; `busy` falls.
- Sweep START=10, END=20, STEP=4, DWELL=3 → words 10, 14, 18, 20 spaced 5 cycles apart, then `done`.
- Sweep START=100, END=127, STEP=20 → words 100, 120, 127; no wrap to low values.
- Stop issued during DWELL after the first word → no further non-zero `afu_data`; `busy` = 0 next cycle; no `done`.
- Write STEP while busy, and start with START=50, END=10 → ignored; STATUS.err = 1; clear via STATUS write → err = 0.
- With TRIANGLE_EN, START=0, END=8, STEP=4, DWELL=0 → 0, 4, 8, 4, 0, 4… every 2 cycles until stop.
